// File: rtl/topo2a_ad_proj_div_pkg.sv
// Shared widths, counter sizing and FSM encoding for the sequential unsigned divider.
package topo2a_ad_proj_div_pkg;

    localparam int DIV_DVD_W = 20;
    localparam int DIV_DSR_W = 6;

    // Counter must hold the full bit count, hence +1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_DVD_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } div_state_e;

endpackage

// File: rtl/topo2a_ad_proj_udiv_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module topo2a_ad_proj_udiv_step
    import topo2a_ad_proj_div_pkg::*;
#(
    parameter int DIVISOR_WIDTH = DIV_DSR_W
) (
    input  logic [DIVISOR_WIDTH:0]   rem_in,
    input  logic                     bit_in,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    output logic [DIVISOR_WIDTH:0]   rem_out,
    output logic                     q_bit
);

    logic [DIVISOR_WIDTH+1:0] shifted;
    logic [DIVISOR_WIDTH+1:0] diff;

    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {2'b00, divisor};
    assign q_bit   = (shifted >= {2'b00, divisor});
    // Either result is below 2*divisor, so the top bit can be dropped safely.
    assign rem_out = q_bit ? diff[DIVISOR_WIDTH:0] : shifted[DIVISOR_WIDTH:0];

endmodule

// File: rtl/topo2a_ad_proj_udiv_20ns_6ns_seq.sv
// Sequential unsigned divider: one quotient bit per cycle, valid/ready on both sides.
module topo2a_ad_proj_udiv_20ns_6ns_seq
    import topo2a_ad_proj_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DIV_DVD_W,
    parameter int DIVISOR_WIDTH  = DIV_DSR_W
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div0
);

    localparam int CNT_W = cnt_width(DIVIDEND_WIDTH);

    div_state_e                state;
    logic [CNT_W-1:0]          cnt;
    logic [DIVIDEND_WIDTH-1:0] dvd_q;
    logic [DIVISOR_WIDTH:0]    rem_q;
    logic [DIVISOR_WIDTH-1:0]  dsr_q;
    logic [DIVISOR_WIDTH:0]    rem_nxt;
    logic                      q_bit;

    topo2a_ad_proj_udiv_step #(
        .DIVISOR_WIDTH(DIVISOR_WIDTH)
    ) u_step (
        .rem_in (rem_q),
        .bit_in (dvd_q[DIVIDEND_WIDTH-1]),
        .divisor(dsr_q),
        .rem_out(rem_nxt),
        .q_bit  (q_bit)
    );

    // Dividend register doubles as the quotient accumulator: bits shift out the top, quotient bits in the bottom.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div0      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        dvd_q    <= dividend;
                        dsr_q    <= divisor;
                        rem_q    <= '0;
                        cnt      <= CNT_W'(DIVIDEND_WIDTH);
                        in_ready <= 1'b0;
                        state    <= ST_CALC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_CALC: begin
                    dvd_q <= {dvd_q[DIVIDEND_WIDTH-2:0], q_bit};
                    rem_q <= rem_nxt;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        if (dsr_q == '0) begin
                            quotient  <= '1;
                            remainder <= '0;
                            div0      <= 1'b1;
                        end else begin
                            quotient  <= {dvd_q[DIVIDEND_WIDTH-2:0], q_bit};
                            remainder <= rem_nxt[DIVISOR_WIDTH-1:0];
                            div0      <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        quotient  <= '0;
                        remainder <= '0;
                        div0      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_topo2a_ad_proj_udiv_20ns_6ns_seq.sv
// Randomized self-checking bench for the sequential divider against a plain-arithmetic model.
module tb_topo2a_ad_proj_udiv_20ns_6ns_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] dividend = '0;
    logic [5:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] quotient;
    logic [5:0]  remainder;
    logic        div0;

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    topo2a_ad_proj_udiv_20ns_6ns_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder),
        .div0     (div0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: mathematical floor division, zero divisor gives all-ones / 0 / flag.
    task automatic model(input logic [19:0] a, input logic [5:0] b,
                         output logic [19:0] q, output logic [5:0] r, output logic d0);
        int unsigned ua, ub;
        ua = a;
        ub = b;
        if (ub == 0) begin
            q = 20'hFFFFF; r = 6'd0; d0 = 1'b1;
        end else begin
            q = 20'(ua / ub); r = 6'(ua % ub); d0 = 1'b0;
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge ap_clk);
        while (!in_ready && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        if (!in_ready) chk({tag, "_ready_timeout"}, 0, 1);
    endtask

    // Present one operand pair, check latency, hold in DONE for 'hold' cycles, then hand off.
    task automatic run_op(input string tag, input logic [19:0] a, input logic [5:0] b,
                          input int hold, input bit noisy);
        logic [19:0] eq;
        logic [5:0]  er;
        logic        ed;
        int          lat;
        bit          zero_ok;
        model(a, b, eq, er, ed);
        wait_ready(tag);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        zero_ok = 1'b1;
        while (lat < 40) begin
            if (noisy) begin
                in_valid  = 1'($urandom);
                dividend  = 20'($urandom);
                divisor   = 6'($urandom);
                out_ready = 1'($urandom);
            end
            @(posedge ap_clk);
            #1;
            lat++;
            if (out_valid) break;
            if (in_ready || quotient != 0 || remainder != 0 || div0) zero_ok = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_latency"}, lat, 20);
        chk({tag, "_calc_quiet"}, zero_ok, 1);
        chk({tag, "_quot"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
        chk({tag, "_div0"}, div0, ed);
        for (int i = 0; i < hold; i++) begin
            @(posedge ap_clk);
            #1;
            chk({tag, "_hold"}, {in_ready, out_valid, div0, remainder, quotient}, {1'b0, 1'b1, ed, er, eq});
        end
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_handoff"}, {in_ready, out_valid, quotient}, {1'b1, 1'b0, 20'd0});
    endtask

    initial begin
        logic [19:0] ra;
        logic [5:0]  rb;

        #12;
        chk("rst_outputs", {in_ready, out_valid, div0, remainder, quotient}, '0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("rst_release_ready", in_ready, 1);

        run_op("d1000_7", 20'd1000, 6'd7, 0, 1'b0);
        run_op("dmax_1", 20'd1048575, 6'd1, 0, 1'b0);
        run_op("dmax_63", 20'd1048575, 6'd63, 0, 1'b0);
        run_op("d12345_0", 20'd12345, 6'd0, 0, 1'b0);
        run_op("stall5", 20'd54321, 6'd17, 5, 1'b0);
        run_op("noisy", 20'd777777, 6'd45, 1, 1'b1);

        // Reset in the middle of CALC must abort with no result.
        wait_ready("midrst");
        in_valid = 1'b1;
        dividend = 20'd1000;
        divisor  = 6'd7;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {in_ready, out_valid, div0, remainder, quotient}, '0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("midrst_idle", {in_ready, out_valid}, 2'b10);
        begin
            bit seen;
            seen = 1'b0;
            repeat (25) begin
                @(posedge ap_clk);
                #1;
                if (out_valid) seen = 1'b1;
            end
            chk("midrst_no_result", seen, 0);
        end
        run_op("d100_3", 20'd100, 6'd3, 0, 1'b0);

        // Reset while holding a result in DONE.
        wait_ready("donerst");
        in_valid = 1'b1;
        dividend = 20'd99;
        divisor  = 6'd5;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        repeat (22) @(posedge ap_clk);
        #1;
        chk("donerst_valid", out_valid, 1);
        ap_rst_n = 1'b0;
        #1;
        chk("donerst_outputs", {in_ready, out_valid, div0, remainder, quotient}, '0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        for (int k = 0; k < 30; k++) begin
            ra = 20'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = 6'd0;
                1:       rb = 6'd63;
                default: rb = 6'($urandom);
            endcase
            run_op("rand", ra, rb, $urandom_range(0, 3), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/topo2a_ad_proj_udiv_20ns_6ns_seq.md
TOPO2A_AD_PROJ_UDIV_20NS_6NS_SEQ -- requirements
Module: topo2a_ad_proj_udiv_20ns_6ns_seq

Interface
REQ-001 SHALL have parameter DIVIDEND_WIDTH, default 20, meaning the unsigned dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_WIDTH, default 6, meaning the unsigned divisor and remainder width.
REQ-003 SHALL have port ap_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ap_rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, operand pair presented.
REQ-006 SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 SHALL have port dividend, input, DIVIDEND_WIDTH, unsigned numerator.
REQ-008 SHALL have port divisor, input, DIVISOR_WIDTH, unsigned denominator.
REQ-009 SHALL have port out_valid, output, 1, result held and valid.
REQ-010 SHALL have port out_ready, input, 1, consumer takes result.
REQ-011 SHALL have port quotient, output, DIVIDEND_WIDTH, floor(dividend/divisor).
REQ-012 SHALL have port remainder, output, DIVISOR_WIDTH, dividend mod divisor.
REQ-013 SHALL have port div0, output, 1, result came from a zero divisor.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-016 SHALL capture dividend and divisor on the edge where in_valid and in_ready are both 1, then enter CALC with the bit counter loaded to DIVIDEND_WIDTH.
REQ-017 SHALL in CALC resolve one quotient bit per cycle, MSB first, by restoring division: shift the partial remainder left with the next dividend bit, subtract the divisor if it fits, and set the quotient bit.
REQ-018 SHALL hold the partial remainder in DIVISOR_WIDTH+1 bits so that the trial subtraction never overflows.
REQ-019 SHALL decrement the counter once per CALC cycle and move to DONE on the edge that completes the last bit, giving out_valid exactly DIVIDEND_WIDTH edges after the accepting edge (20 by default).
REQ-020 SHALL hold quotient, remainder and div0 stable in DONE until out_valid and out_ready are both 1, then return to IDLE on that edge.
REQ-021 SHALL NOT accept new operands on the same edge as a result handoff; in_ready rises the cycle after the handoff.
REQ-022 SHALL on a zero divisor still spend DIVIDEND_WIDTH cycles in CALC, then present quotient all ones, remainder 0 and div0=1.
REQ-023 SHALL drive div0=0 for every nonzero divisor.
REQ-024 SHALL ignore in_valid, dividend and divisor in CALC and DONE.
REQ-025 SHALL ignore out_ready outside DONE.
REQ-026 SHALL keep quotient, remainder and div0 at 0 in IDLE and CALC; they update only on entry to DONE.

Reset
REQ-027 SHALL on ap_rst_n=0, at any time including mid-CALC or DONE, immediately enter IDLE.
REQ-028 SHALL during reset clear the counter and all operand and result registers.
REQ-029 SHALL during reset drive in_ready=0, out_valid=0, quotient=0, remainder=0 and div0=0.
REQ-030 SHALL leave reset into IDLE with in_ready=1 on the first rising edge after ap_rst_n deasserts.
REQ-031 SHALL discard any operation in progress when reset is asserted and produce no result for it.

Structure
REQ-032 SHALL place the width defaults, the counter width ($clog2(DIVIDEND_WIDTH+1)) and the FSM state enum in the shared package topo2a_ad_proj_div_pkg.
REQ-033 SHALL implement the single-bit trial-subtract as one combinational sub-module, topo2a_ad_proj_udiv_step, instantiated once.
REQ-034 SHALL use no multipliers, no dividers and no inferred RAM.

Verification
REQ-035 SHALL cover 1000/7 -> quotient=142, remainder=6, div0=0, out_valid exactly 20 cycles after accept.
REQ-036 SHALL cover 1048575/1 -> quotient=1048575, remainder=0; and 1048575/63 -> quotient=16644, remainder=3.
REQ-037 SHALL cover 12345/0 -> quotient=0xFFFFF, remainder=0, div0=1, same 20-cycle latency.
REQ-038 SHALL cover out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0 throughout; handoff on the 6th cycle, then in_ready=1 the next cycle.
REQ-039 SHALL cover ap_rst_n pulsed low at CALC cycle 10 -> all outputs 0 immediately, IDLE after release, and a following 100/3 gives quotient=33, remainder=1.
REQ-040 SHALL cover in_valid toggling with new operands during CALC -> ignored; the original result is returned.
